// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode/operand stage with MEM/WB forwarding, load-use stall and ID/EX register.
// Optional ID_PERF_CNT_EN adds stall/flush event counters.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic            mem_regwrite,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    input  logic            flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_illegal
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            illegal;
    } ex_t;

    ex_t ex_d, ex_q, bubble;
    logic [6:0] op;
    logic [4:0] rd;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic legal, use1, use2, load;
    logic [XLEN-1:0] imm, fwd1, fwd2;

    assign op  = if_instr[6:0];
    assign rd  = if_instr[11:7];
    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];

    assign is_lui    = op == 7'b0110111;
    assign is_auipc  = op == 7'b0010111;
    assign is_jal    = op == 7'b1101111;
    assign is_jalr   = op == 7'b1100111;
    assign is_branch = op == 7'b1100011;
    assign is_load   = op == 7'b0000011;
    assign is_store  = op == 7'b0100011;
    assign is_opimm  = op == 7'b0010011;
    assign is_op     = op == 7'b0110011;
    assign legal = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                   is_opimm | is_op | op == 7'b0001111 | op == 7'b1110011;
    assign use1 = is_jalr | is_branch | is_load | is_store | is_opimm | is_op;
    assign use2 = is_branch | is_store | is_op;

    always_comb
        imm = (is_jalr | is_load | is_opimm) ? {{20{if_instr[31]}}, if_instr[31:20]} :
              is_store  ? {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]} :
              is_branch ? {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0} :
              (is_lui | is_auipc) ? {if_instr[31:12], 12'b0} :
              is_jal    ? {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0} :
              '0;

    // WB match covers the regfile write happening on this same edge.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] a, input logic [XLEN-1:0] d);
        return a == 5'd0 ? '0 :
               (mem_regwrite && mem_rd == a) ? mem_result :
               (wb_regwrite && wb_rd == a) ? wb_result : d;
    endfunction

    assign fwd1 = fwd(rs1, rd1);
    assign fwd2 = fwd(rs2, rd2);

    assign id_stall = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & if_valid & ~flush &
                      ((use1 & (rs1 == ex_q.rd)) | (use2 & (rs2 == ex_q.rd)));
    assign load = if_valid & ~flush & ~id_stall;

    always_comb begin
        bubble    = '0;
        bubble.pc = RESET_PC;
        ex_d      = bubble;
        if (load) begin
            ex_d.valid    = 1'b1;
            ex_d.pc       = if_pc;
            ex_d.rs1_val  = fwd1;
            ex_d.rs2_val  = fwd2;
            ex_d.imm      = imm;
            ex_d.rd       = rd;
            ex_d.opcode   = op;
            ex_d.funct3   = if_instr[14:12];
            ex_d.funct7b5 = if_instr[30];
            ex_d.regwrite = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op) & (rd != 5'd0);
            ex_d.memread  = is_load;
            ex_d.memwrite = is_store;
            ex_d.illegal  = ~legal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= bubble;
        else     ex_q <= ex_d;
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_val  = ex_q.rs1_val;
    assign ex_rs2_val  = ex_q.rs2_val;
    assign ex_imm      = ex_q.imm;
    assign ex_rd       = ex_q.rd;
    assign ex_opcode   = ex_q.opcode;
    assign ex_funct3   = ex_q.funct3;
    assign ex_funct7b5 = ex_q.funct7b5;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_illegal  = ex_q.illegal;

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(id_stall);
            flush_cnt_q <= flush_cnt_q + 32'(flush);
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of decode, immediates, forwarding, load-use stall and flush.
module tb_id_ex_stage;
    logic        clk = 0;
    logic        rst, if_valid, mem_regwrite, wb_regwrite, flush;
    logic [31:0] if_instr, if_pc, rd1, rd2, mem_result, wb_result;
    logic [4:0]  mem_rd, wb_rd, rs1, rs2, ex_rd;
    logic        id_stall, ex_valid, ex_funct7b5, ex_regwrite, ex_memread, ex_memwrite, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
`ifdef ID_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
    int tests = 0, fails = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_illegal(ex_illegal)
`ifdef ID_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        #1;
    endtask

    initial begin
        rst = 1; flush = 0; mem_regwrite = 0; wb_regwrite = 0;
        mem_rd = 0; wb_rd = 0; mem_result = 0; wb_result = 0; rd1 = 10; rd2 = 20;
        drive(1, 32'hFFB08193, 32'h100);
        step; step;
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_regwrite", 32'(ex_regwrite), 0);
        chk("rst_pc", ex_pc, 0);
        rst = 0;

        chk("rs1_addr", 32'(rs1), 1);
        step;
        chk("addi_valid", 32'(ex_valid), 1);
        chk("addi_rd", 32'(ex_rd), 3);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFB);
        chk("addi_rs1", ex_rs1_val, 10);
        chk("addi_regwrite", 32'(ex_regwrite), 1);
        chk("addi_pc", ex_pc, 32'h100);

        drive(1, 32'h0020A423, 32'h104);
        step;
        chk("sw_imm", ex_imm, 8);
        chk("sw_memwrite", 32'(ex_memwrite), 1);
        chk("sw_regwrite", 32'(ex_regwrite), 0);
        chk("sw_rs2", ex_rs2_val, 20);
        chk("sw_funct3", 32'(ex_funct3), 2);

        drive(1, 32'hFE208EE3, 32'h108);
        step;
        chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
        drive(1, 32'h001000EF, 32'h10C);
        step;
        chk("jal_imm", ex_imm, 32'h0000_0800);
        chk("jal_regwrite", 32'(ex_regwrite), 1);
        drive(1, 32'h00108013, 32'h110);
        step;
        chk("rd0_regwrite", 32'(ex_regwrite), 0);

        rd1 = 1; rd2 = 1;
        wb_regwrite = 1; wb_rd = 1; wb_result = 7;
        mem_regwrite = 1; mem_rd = 1; mem_result = 9;
        drive(1, 32'h00108233, 32'h114);
        step;
        chk("fwd_mem_rs1", ex_rs1_val, 9);
        chk("fwd_mem_rs2", ex_rs2_val, 9);
        mem_regwrite = 0;
        step;
        chk("fwd_wb_rs1", ex_rs1_val, 7);
        chk("fwd_wb_rs2", ex_rs2_val, 7);
        wb_regwrite = 1; wb_rd = 0; mem_regwrite = 1; mem_rd = 0; rd1 = 32'h55; rd2 = 32'h55;
        drive(1, 32'h00000233, 32'h118);
        step;
        chk("fwd_x0_rs1", ex_rs1_val, 0);
        chk("fwd_x0_rs2", ex_rs2_val, 0);
        mem_regwrite = 0; wb_regwrite = 0; rd1 = 11; rd2 = 22;

        drive(1, 32'h0000A283, 32'h200);
        step;
        chk("lw_memread", 32'(ex_memread), 1);
        drive(1, 32'h00228333, 32'h204);
        chk("lu_stall", 32'(id_stall), 1);
        step;
        chk("lu_bubble", 32'(ex_valid), 0);
        chk("lu_bubble_pc", ex_pc, 0);
        wb_regwrite = 1; wb_rd = 5; wb_result = 32'hDEAD_BEEF;
        #1;
        chk("lu_stall_once", 32'(id_stall), 0);
        step;
        chk("lu_issue_valid", 32'(ex_valid), 1);
        chk("lu_issue_rs1", ex_rs1_val, 32'hDEAD_BEEF);
        chk("lu_issue_rs2", ex_rs2_val, 22);
        chk("lu_issue_rd", 32'(ex_rd), 6);
        wb_regwrite = 0;

        drive(1, 32'h0000A283, 32'h300);
        step;
        drive(1, 32'h000282B7, 32'h304);
        chk("lui_nostall", 32'(id_stall), 0);
        step;
        chk("lui_valid", 32'(ex_valid), 1);
        chk("lui_imm", ex_imm, 32'h0002_8000);

        drive(1, 32'h0000A283, 32'h400);
        step;
        drive(1, 32'h00228333, 32'h404);
        flush = 1;
        #1;
        chk("flush_nostall", 32'(id_stall), 0);
        step;
        flush = 0;
        chk("flush_bubble", 32'(ex_valid), 0);
        chk("flush_regwrite", 32'(ex_regwrite), 0);

        drive(0, 32'h00108233, 32'h500);
        step;
        chk("novalid_bubble", 32'(ex_valid), 0);
        drive(1, 32'h000002FF, 32'h504);
        step;
        chk("illegal_valid", 32'(ex_valid), 1);
        chk("illegal_flag", 32'(ex_illegal), 1);
        chk("illegal_regwrite", 32'(ex_regwrite), 0);

`ifdef ID_PERF_CNT_EN
        rst = 1;
        step;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0000A283, 32'h600);
            step;
            drive(1, 32'h00228333, 32'h604);
            step;
        end
        drive(0, 32'h0, 32'h0);
        flush = 1;
        step; step;
        flush = 0;
        chk("perf_stall", perf_stall_cnt, 3);
        chk("perf_flush", perf_flush_cnt, 2);
        rst = 1;
        step;
        rst = 0;
        chk("perf_stall_rst", perf_stall_cnt, 0);
        chk("perf_flush_rst", perf_flush_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
